// File: rtl/store_trace_checker.sv
// Checks a processor's store stream, in order, against a table of expected (address, data) pairs.
// Declares halt when the PC stops changing, times out runaway programs and keeps sticky verdict flags.
module store_trace_checker #(
   parameter int NUM_EXP        = 16,
   parameter int IDX_W          = 4,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int HALT_CYCLES    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             exp_we,
   input  logic [IDX_W-1:0] exp_idx,
   input  logic [31:0]      exp_adr,
   input  logic [31:0]      exp_data,
   input  logic [IDX_W:0]   exp_num,
   input  logic             start,
   input  logic             MemWrite,
   input  logic [31:0]      DataAdr,
   input  logic [31:0]      WriteData,
   input  logic [31:0]      PCO,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [IDX_W:0]   err_idx,
   output logic [31:0]      err_adr,
   output logic [31:0]      err_data,
   output logic [IDX_W:0]   store_count
);
   localparam int              ST_W    = $clog2(HALT_CYCLES + 1);
   localparam logic [IDX_W:0]  NUM_MAX = (IDX_W + 1)'(NUM_EXP);
   localparam logic [ST_W-1:0] HALT_N  = ST_W'(HALT_CYCLES);
   localparam logic [CNT_W-1:0] TMO_N  = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

   state_t           r_state;
   logic [31:0]      r_tbl_adr  [NUM_EXP];
   logic [31:0]      r_tbl_data [NUM_EXP];
   logic [IDX_W:0]   r_ptr;
   logic [IDX_W:0]   r_num;
   logic [CNT_W-1:0] r_cyc;
   logic [ST_W-1:0]  r_stable;
   logic [31:0]      r_pc_q;
   logic             r_busy, r_pass, r_fail, r_tmo;
   logic [IDX_W:0]   r_err_idx;
   logic [31:0]      r_err_adr, r_err_data;

   logic [IDX_W:0]   w_num_clamp;
   logic [IDX_W-1:0] w_rd_idx;
   logic             w_match, w_extra, w_bad, w_halt, w_tmo;
   logic [IDX_W:0]   w_ptr_nx;
   logic [ST_W-1:0]  w_stable_nx;
   logic [CNT_W-1:0] w_cyc_nx;

   assign w_num_clamp = (exp_num > NUM_MAX) ? NUM_MAX : exp_num;
   assign w_rd_idx    = r_ptr[IDX_W-1:0];
   assign w_match     = (DataAdr == r_tbl_adr[w_rd_idx]) && (WriteData == r_tbl_data[w_rd_idx]);
   assign w_extra     = MemWrite && (r_ptr == r_num);
   assign w_bad       = MemWrite && !w_extra && !w_match;
   // A matching store advances the pointer before halt/timeout are judged in the same cycle.
   assign w_ptr_nx    = (MemWrite && !w_extra && w_match) ? r_ptr + (IDX_W + 1)'(1) : r_ptr;
   assign w_stable_nx = (PCO != r_pc_q) ? '0 :
                        (r_stable == HALT_N) ? r_stable : r_stable + ST_W'(1);
   assign w_halt      = (w_stable_nx == HALT_N);
   assign w_cyc_nx    = r_cyc + CNT_W'(1);
   assign w_tmo       = (w_cyc_nx == TMO_N);

   always_ff @(posedge clk) begin
      if (exp_we && r_state != S_RUN) begin
         r_tbl_adr[exp_idx]  <= exp_adr;
         r_tbl_data[exp_idx] <= exp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_num      <= '0;
         r_cyc      <= '0;
         r_stable   <= '0;
         r_pc_q     <= '0;
         r_busy     <= 1'b0;
         r_pass     <= 1'b0;
         r_fail     <= 1'b0;
         r_tmo      <= 1'b0;
         r_err_idx  <= '0;
         r_err_adr  <= '0;
         r_err_data <= '0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_cyc    <= w_cyc_nx;
               r_stable <= w_stable_nx;
               r_pc_q   <= PCO;
               if (w_extra || w_bad) begin
                  r_state    <= S_FAIL;
                  r_busy     <= 1'b0;
                  r_fail     <= 1'b1;
                  r_err_idx  <= r_ptr;
                  r_err_adr  <= DataAdr;
                  r_err_data <= WriteData;
               end else begin
                  r_ptr <= w_ptr_nx;
                  if (w_halt && w_ptr_nx == r_num) begin
                     r_state <= S_PASS;
                     r_busy  <= 1'b0;
                     r_pass  <= 1'b1;
                  end else if (w_halt) begin
                     r_state   <= S_FAIL;
                     r_busy    <= 1'b0;
                     r_fail    <= 1'b1;
                     r_err_idx <= w_ptr_nx;
                  end else if (w_tmo) begin
                     r_state   <= S_TMO;
                     r_busy    <= 1'b0;
                     r_tmo     <= 1'b1;
                     r_err_idx <= w_ptr_nx;
                  end
               end
            end
            default: begin
               if (start) begin
                  r_state    <= S_RUN;
                  r_busy     <= 1'b1;
                  r_pass     <= 1'b0;
                  r_fail     <= 1'b0;
                  r_tmo      <= 1'b0;
                  r_err_idx  <= '0;
                  r_err_adr  <= '0;
                  r_err_data <= '0;
                  r_ptr      <= '0;
                  r_cyc      <= '0;
                  r_stable   <= '0;
                  r_num      <= w_num_clamp;
                  r_pc_q     <= PCO;
               end
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign pass        = r_pass;
   assign fail        = r_fail;
   assign timeout     = r_tmo;
   assign err_idx     = r_err_idx;
   assign err_adr     = r_err_adr;
   assign err_data    = r_err_data;
   assign store_count = r_ptr;
endmodule

// File: tb/tb_store_trace_checker.sv
// Scoreboard bench: each run's outcome is predicted from the store/PC trace and pushed to a queue;
// a monitor pops and compares when busy drops.
module tb_store_trace_checker;
   localparam int NUM_EXP = 16;
   localparam int IDX_W   = 4;
   localparam int CNT_W   = 16;
   localparam int TMO     = 64;
   localparam int HALT    = 4;
   localparam int MAXC    = 80;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             exp_we = 1'b0;
   logic [IDX_W-1:0] exp_idx = '0;
   logic [31:0]      exp_adr = '0;
   logic [31:0]      exp_data = '0;
   logic [IDX_W:0]   exp_num = '0;
   logic             start = 1'b0;
   logic             MemWrite = 1'b0;
   logic [31:0]      DataAdr = '0;
   logic [31:0]      WriteData = '0;
   logic [31:0]      PCO = '0;
   logic             busy, pass, fail, timeout;
   logic [IDX_W:0]   err_idx, store_count;
   logic [31:0]      err_adr, err_data;

   store_trace_checker #(
      .NUM_EXP(NUM_EXP), .IDX_W(IDX_W), .CNT_W(CNT_W),
      .TIMEOUT_CYCLES(TMO), .HALT_CYCLES(HALT)
   ) dut (
      .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx),
      .exp_adr(exp_adr), .exp_data(exp_data), .exp_num(exp_num), .start(start),
      .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData), .PCO(PCO),
      .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
      .err_idx(err_idx), .err_adr(err_adr), .err_data(err_data), .store_count(store_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          p;
      bit          f;
      bit          t;
      int          idx;
      logic [31:0] ea;
      logic [31:0] ed;
      int          cnt;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          n_pass = 0;
   int          n_tot  = 0;
   int          n_run  = 0;
   logic [31:0] m_adr [NUM_EXP];
   logic [31:0] m_dat [NUM_EXP];
   bit          s_mw  [MAXC];
   logic [31:0] s_adr [MAXC];
   logic [31:0] s_dat [MAXC];
   logic [31:0] s_pc  [MAXC];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tot++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
   endtask

   // Walk the trace: stores are matched in order against the table, halt is a window of
   // HALT+1 equal PC samples (sample 0 is the PC at start), timeout is RUN cycle TMO.
   function automatic exp_t model(input int num);
      exp_t e;
      int   numc;
      int   k;
      bit   halt;
      numc = (num > NUM_EXP) ? NUM_EXP : num;
      k = 0;
      e.p = 0; e.f = 0; e.t = 0; e.idx = 0; e.ea = 0; e.ed = 0; e.cnt = 0; e.lat = 0;
      for (int t = 1; t <= TMO; t++) begin
         if (s_mw[t]) begin
            halt = (k >= numc);
            if (!halt) halt = (s_adr[t] != m_adr[k]) || (s_dat[t] != m_dat[k]);
            if (halt) begin
               e.f = 1; e.idx = k; e.ea = s_adr[t]; e.ed = s_dat[t]; e.cnt = k; e.lat = t;
               return e;
            end
            k++;
         end
         halt = (t >= HALT);
         for (int j = t - HALT; j < t; j++)
            if (j >= 0 && s_pc[j] != s_pc[t]) halt = 0;
         if (halt) begin
            e.p = (k == numc); e.f = (k != numc); e.idx = (k != numc) ? k : 0;
            e.cnt = k; e.lat = t;
            return e;
         end
         if (t == TMO) begin
            e.t = 1; e.idx = k; e.cnt = k; e.lat = t;
            return e;
         end
      end
      return e;
   endfunction

   initial begin : monitor
      exp_t e;
      int   hi;
      bit   prev_busy;
      hi = 0;
      prev_busy = 0;
      forever begin
         @(negedge clk);
         if (busy) hi++;
         else if (prev_busy) begin
            if (sb.size() == 0) begin
               n_tot++;
               $display("FAIL unexpected_done: got busy fall, required none pending");
            end else begin
               e = sb.pop_front();
               n_run++;
               $display("run %0d: pass=%0b fail=%0b timeout=%0b err_idx=%0d cnt=%0d cycles=%0d",
                        n_run, pass, fail, timeout, err_idx, store_count, hi);
               chk("pass", 32'(pass), 32'(e.p));
               chk("fail", 32'(fail), 32'(e.f));
               chk("timeout", 32'(timeout), 32'(e.t));
               chk("err_idx", 32'(err_idx), e.idx);
               chk("err_adr", err_adr, e.ea);
               chk("err_data", err_data, e.ed);
               chk("store_count", 32'(store_count), e.cnt);
               chk("latency", hi, e.lat);
            end
            hi = 0;
         end
         prev_busy = busy;
      end
   end

   task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
      exp_we = 1; exp_idx = IDX_W'(i); exp_adr = a; exp_data = d;
      @(posedge clk); #1;
      exp_we = 0;
      m_adr[i] = a; m_dat[i] = d;
   endtask

   task automatic clear_trace();
      for (int t = 0; t < MAXC; t++) begin
         s_mw[t] = 0; s_adr[t] = 0; s_dat[t] = 0; s_pc[t] = 0;
      end
   endtask

   // PC ramps by 4 from p0 until hold_from, then sits at hv.
   task automatic pc_trace(input logic [31:0] p0, input int hold_from, input logic [31:0] hv);
      for (int t = 0; t < MAXC; t++) s_pc[t] = (t < hold_from) ? p0 + 32'(4 * t) : hv;
   endtask

   task automatic st(input int c, input logic [31:0] a, input logic [31:0] d);
      s_mw[c] = 1; s_adr[c] = a; s_dat[c] = d;
   endtask

   task automatic run(input int num, input bit noise, input int rst_at);
      exp_t e;
      int   last;
      e = model(num);
      if (rst_at > 0) begin
         e.p = 0; e.f = 0; e.t = 0; e.idx = 0; e.ea = 0; e.ed = 0; e.cnt = 0; e.lat = rst_at;
      end
      sb.push_back(e);
      start = 1; exp_num = num[IDX_W:0]; PCO = s_pc[0]; MemWrite = 0;
      @(posedge clk); #1;
      start = 0;
      last = (rst_at > 0) ? rst_at : e.lat;
      for (int t = 1; t <= last; t++) begin
         PCO = s_pc[t]; MemWrite = s_mw[t]; DataAdr = s_adr[t]; WriteData = s_dat[t];
         if (t == rst_at) reset = 0;
         if (noise) begin
            exp_we   = 1'($urandom_range(0, 1));
            exp_idx  = IDX_W'($urandom_range(0, NUM_EXP - 1));
            exp_adr  = $urandom;
            exp_data = $urandom;
            start    = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
      end
      reset = 1; MemWrite = 0; exp_we = 0; start = 0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      if (sb.size() != 0) begin
         n_tot++;
         $display("FAIL run_done: got busy=%0b after bound, required run finished", busy);
         sb.delete();
      end
   endtask

   task automatic rand_run();
      int          num;
      int          hold;
      int          c;
      int          nst;
      logic [31:0] p0;
      num = $urandom_range(0, 6);
      for (int i = 0; i < num; i++) load(i, 32'($urandom_range(0, 1023)) << 2, $urandom);
      clear_trace();
      p0 = 32'($urandom_range(0, 255)) << 2;
      hold = $urandom_range(4, 75);
      s_pc[0] = p0;
      for (int t = 1; t < MAXC; t++)
         s_pc[t] = (t >= hold || $urandom_range(0, 9) == 0) ? s_pc[t-1] : s_pc[t-1] + 32'd4;
      nst = num + (($urandom_range(0, 3) == 0) ? 1 : 0);
      if (num > 0 && $urandom_range(0, 3) == 0) nst--;
      c = 0;
      for (int s = 0; s < nst; s++) begin
         c += $urandom_range(1, 3);
         if (c < MAXC) begin
            if (s < num) st(c, m_adr[s], m_dat[s]);
            else st(c, $urandom, $urandom);
            if ($urandom_range(0, 7) == 0) s_dat[c] = s_dat[c] ^ (32'd1 << $urandom_range(0, 31));
         end
      end
      run(num, 1, 0);
   endtask

   initial begin
      reset = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pass", 32'(pass), 0);
      chk("rst_fail", 32'(fail), 0);
      chk("rst_timeout", 32'(timeout), 0);
      chk("rst_err_idx", 32'(err_idx), 0);
      chk("rst_err_adr", err_adr, 0);
      chk("rst_err_data", err_data, 0);
      chk("rst_store_count", 32'(store_count), 0);
      reset = 1;
      @(posedge clk); #1;

      load(0, 32'h64, 32'd7);
      load(1, 32'h68, 32'hA);
      // matching stores then halt at 0x3C
      clear_trace(); pc_trace(0, 3, 32'h3C); st(1, 32'h64, 7); st(2, 32'h68, 32'hA); run(2, 0, 0);
      clear_trace(); pc_trace(0, 3, 32'h3C); st(1, 32'h64, 7); st(2, 32'h68, 32'hB); run(2, 0, 0);
      clear_trace(); pc_trace(0, 4, 32'h3C); st(1, 32'h64, 7); st(2, 32'h68, 32'hA);
      st(3, 32'h6C, 1); run(2, 0, 0);
      clear_trace(); pc_trace(0, 3, 32'h3C); st(1, 32'h64, 7); run(2, 0, 0);
      clear_trace(); pc_trace(0, MAXC, 0); run(2, 0, 0);
      // reset mid-run, then the untouched table must still drive a passing run
      clear_trace(); pc_trace(0, MAXC, 0); st(1, 32'h64, 7); run(2, 0, 10);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_count", 32'(store_count), 0);
      clear_trace(); pc_trace(0, 3, 32'h3C); st(1, 32'h64, 7); st(2, 32'h68, 32'hA); run(2, 0, 0);
      // bad store lands on the timeout cycle
      clear_trace(); pc_trace(0, MAXC, 0); st(1, 32'h64, 7); st(2, 32'h68, 32'hA);
      st(TMO, 32'h70, 5); run(2, 0, 0);
      clear_trace(); pc_trace(32'h100, 0, 32'h100); run(0, 0, 0);
      clear_trace(); pc_trace(32'h100, 5, 32'h200); st(2, 32'h64, 7); run(0, 0, 0);
      // exp_num above table depth clamps to a full table
      for (int i = 0; i < NUM_EXP; i++) load(i, 32'h1000 + 32'(4 * i), 32'(i * 3 + 1));
      clear_trace(); pc_trace(0, 20, 32'h200);
      for (int i = 0; i < NUM_EXP; i++) st(i + 1, m_adr[i], m_dat[i]);
      run(31, 0, 0);

      repeat (30) rand_run();

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
